// File: rtl/piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_tx
// Description : Parallel-in serial-out transmitter. Takes a WIDTH-bit word
//               through a valid/ready handshake and shifts it out one bit
//               per clock with a framing strobe. Words can follow each other
//               with no idle gap: the next word is accepted in the last-bit
//               cycle of the current one.
// Ports       : clk         - rising-edge clock
//               reset       - synchronous, active-high reset
//               data_in     - parallel word, sampled only on an accept edge
//               load_valid  - producer has a word on data_in
//               load_ready  - transmitter can take a word this cycle
//               serial_out  - serial data bit (IDLE_LEVEL outside a frame)
//               frame_out   - high while serial_out carries a data bit
//               busy        - high while a frame is in progress
//               done        - one-cycle pulse during the last bit of a word
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_tx #(
  parameter int   WIDTH      = 4,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             frame_out,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;

  logic             w_last;
  logic             w_cur_bit;
  logic [WIDTH-1:0] w_shifted;

  // The output end of the shift register depends on bit order; the register
  // always moves toward that end so the current bit sits in a fixed position.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_cur_bit = r_shreg[WIDTH-1];
      assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_cur_bit = r_shreg[0];
      assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_state == SHIFT) && (r_cnt == C_LAST);

  // Outputs decode only from state, counter and shift register, so there is
  // no combinational path from load_valid or data_in to any output.
  assign load_ready = (r_state == IDLE) || w_last;
  assign serial_out = (r_state == SHIFT) ? w_cur_bit : IDLE_LEVEL;
  assign frame_out  = (r_state == SHIFT);
  assign busy       = (r_state == SHIFT);
  assign done       = w_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_valid) begin
            r_shreg <= data_in;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_last) begin
            // Last bit: reload for a gap-free frame or fall back to IDLE.
            if (load_valid) begin
              r_shreg <= data_in;
              r_cnt   <= '0;
            end else begin
              r_shreg <= w_shifted;
              r_cnt   <= '0;
              r_state <= IDLE;
            end
          end else begin
            r_shreg <= w_shifted;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_shreg <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
